apb_master_gen2: RTL and testbench

APB_MASTER_GEN2 -- requirements
Module: apb_master_gen2

---
 rtl/apb_master_gen2.sv | 88 ++++++++
 tb/tb_apb_master_gen2.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_gen2.sv
// apb_master_gen2: APB master bridging a valid/ready host port to NSLV APB slaves with wait-state timeout.
module apb_master_gen2 #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int NSLV    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                     PCLK,
  input  logic                     PRESETn,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [DATA_W-1:0]        req_wdata,
  input  logic [DATA_W/8-1:0]      req_strb,
  output logic                     rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_err,
  output logic                     rsp_timeout,
  output logic [NSLV-1:0]          PSEL,
  output logic                     PENABLE,
  output logic                     PWRITE,
  output logic [ADDR_W-1:0]        PADDR,
  output logic [DATA_W-1:0]        PWDATA,
  output logic [DATA_W/8-1:0]      PSTRB,
  input  logic [NSLV-1:0]          PREADY,
  input  logic [NSLV-1:0]          PSLVERR,
  input  logic [NSLV*DATA_W-1:0]   PRDATA
);
  localparam int SW = $clog2(NSLV);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state, state_nx;
  logic [SW-1:0] idx;
  logic [CW-1:0] cnt;
  logic done, tmo, accept;
  always_comb begin
    done = state == ACCESS && PREADY[idx];
    tmo = TIMEOUT != 0 && state == ACCESS && !PREADY[idx] && cnt == CW'(TIMEOUT);
    req_ready = PRESETn && (state == IDLE || done);
    accept = req_valid && req_ready;
    state_nx = accept ? SETUP :
               state == SETUP ? ACCESS :
               (state == ACCESS && !done && !tmo) ? ACCESS : IDLE;
  end
  always_ff @(posedge PCLK)
    state <= !PRESETn ? IDLE : state_nx;
  // A new acceptance is applied last so it overrides the bus release of a completing transfer.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      PSEL <= '0;
      PENABLE <= 1'b0;
      PWRITE <= 1'b0;
      PADDR <= '0;
      PWDATA <= '0;
      PSTRB <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
      rsp_timeout <= 1'b0;
      cnt <= '0;
      idx <= '0;
    end else begin
      rsp_valid <= done || tmo;
      if (done || tmo) begin
        rsp_err <= tmo || PSLVERR[idx];
        rsp_timeout <= tmo;
        rsp_rdata <= (done && !PWRITE && !PSLVERR[idx]) ? PRDATA[idx*DATA_W +: DATA_W] : '0;
        PSEL <= '0;
        PENABLE <= 1'b0;
      end
      if (state == SETUP) begin
        PENABLE <= 1'b1;
        cnt <= '0;
      end
      if (state == ACCESS && !done) cnt <= cnt + 1'b1;
      if (accept) begin
        PSEL <= NSLV'(1) << req_addr[ADDR_W-1 -: SW];
        PENABLE <= 1'b0;
        PADDR <= req_addr;
        PWRITE <= req_write;
        PWDATA <= req_wdata;
        PSTRB <= req_write ? req_strb : '0;
        idx <= req_addr[ADDR_W-1 -: SW];
      end
    end
  end
endmodule

// File: tb/tb_apb_master_gen2.sv
// tb_apb_master_gen2: vector table plus hand-written corner sequences; responses checked through a queue.
module tb_apb_master_gen2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [15:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0] req_strb = '0;
  logic rsp_valid, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [3:0] PSEL;
  logic PENABLE, PWRITE;
  logic [15:0] PADDR;
  logic [31:0] PWDATA;
  logic [3:0] PSTRB;
  logic [3:0] PREADY = '0, PSLVERR = '0;
  logic [127:0] PRDATA = '0;
  apb_master_gen2 dut (
    .PCLK(clk), .PRESETn(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PSTRB(PSTRB), .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
  );
  int total = 0, bad = 0, cyc = 0, nrsp = 0;
  typedef struct {logic [31:0] rdata; logic err; logic tmo;} rsp_t;
  rsp_t exp_q[$];
  rsp_t mon_e;
  int wait_cfg[4];
  int acc_cnt[4];
  logic [3:0] err_cfg = '0;
  logic [31:0] dat_cfg[4];
  typedef struct {
    logic w; logic [15:0] a; logic [31:0] d; logic [3:0] s;
    int wt; logic e; logic [31:0] pd; logic [31:0] xr; logic xe;
  } vec_t;
  vec_t v[6];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  always @(posedge clk) cyc++;
  // Slave model: PREADY rises after wait_cfg wait cycles of ACCESS.
  always @(negedge clk)
    for (int i = 0; i < 4; i++) begin
      PRDATA[i*32 +: 32] = dat_cfg[i];
      PSLVERR[i] = err_cfg[i];
      if (PSEL[i] && PENABLE) begin
        PREADY[i] = acc_cnt[i] >= wait_cfg[i];
        acc_cnt[i]++;
      end else begin
        acc_cnt[i] = 0;
        PREADY[i] = 1'b0;
      end
    end
  always @(negedge clk)
    if (rst_n && rsp_valid) begin
      nrsp++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 want no response");
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, mon_e.rdata);
        chk("rsp_err", rsp_err, mon_e.err);
        chk("rsp_timeout", rsp_timeout, mon_e.tmo);
      end
    end
  task automatic issue(input logic w, input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    req_valid = 1'b1;
    req_write = w;
    req_addr = a;
    req_wdata = d;
    req_strb = s;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (req_ready) begin
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        return;
      end
    end
    req_valid = 1'b0;
    total++;
    bad++;
    $display("FAIL accept_wait: got req_ready=0 for 200 cycles want 1");
  endtask
  task automatic setup_chk(input logic w, input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [3:0] one = 4'b0001;
    chk("setup_psel", PSEL, one << a[15:14]);
    chk("setup_penable", PENABLE, 0);
    chk("setup_paddr", PADDR, a);
    chk("setup_pwrite", PWRITE, w);
    chk("setup_pstrb", PSTRB, w ? s : 4'h0);
    if (w) chk("setup_pwdata", PWDATA, d);
  endtask
  task automatic wait_rsp(input int target);
    for (int i = 0; i < 300; i++) begin
      if (nrsp >= target) return;
      @(posedge clk);
      #1;
    end
    total++;
    bad++;
    $display("FAIL rsp_wait: got %0d responses want %0d", nrsp, target);
  endtask
  task automatic count_access(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (!PENABLE) return;
      n++;
    end
  endtask
  initial begin
    int n, c1, slv, saved;
    for (int i = 0; i < 4; i++) begin
      wait_cfg[i] = 0;
      dat_cfg[i] = 32'h0;
      acc_cnt[i] = 0;
    end
    v[0] = '{1'b1, 16'h4010, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h11111111, 32'h0, 1'b0};
    v[1] = '{1'b0, 16'hC004, 32'h0, 4'hF, 3, 1'b0, 32'h12345678, 32'h12345678, 1'b0};
    v[2] = '{1'b0, 16'h0020, 32'h0, 4'h0, 0, 1'b1, 32'hCAFEF00D, 32'h0, 1'b1};
    v[3] = '{1'b1, 16'h8123, 32'h0BADBEEF, 4'h0, 2, 1'b0, 32'h55, 32'h0, 1'b0};
    v[4] = '{1'b1, 16'h4444, 32'h1, 4'h3, 1, 1'b1, 32'h77, 32'h0, 1'b1};
    v[5] = '{1'b0, 16'h8ABC, 32'h0, 4'h5, 5, 1'b0, 32'hA5A55A5A, 32'hA5A55A5A, 1'b0};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_paddr", PADDR, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_req_ready", req_ready, 1);
    for (int i = 0; i < 6; i++) begin
      slv = int'(v[i].a[15:14]);
      wait_cfg[slv] = v[i].wt;
      err_cfg[slv] = v[i].e;
      dat_cfg[slv] = v[i].pd;
      exp_q.push_back('{v[i].xr, v[i].xe, 1'b0});
      issue(v[i].w, v[i].a, v[i].d, v[i].s);
      setup_chk(v[i].w, v[i].a, v[i].d, v[i].s);
      wait_rsp(nrsp + 1);
      err_cfg[slv] = 1'b0;
    end
    wait_cfg[1] = 0;
    exp_q.push_back('{32'h0, 1'b0, 1'b0});
    issue(1'b1, 16'h4010, 32'hDEADBEEF, 4'hF);
    @(posedge clk);
    #1;
    chk("lat_access_penable", PENABLE, 1);
    chk("lat_access_psel", PSEL, 4'b0010);
    @(posedge clk);
    #1;
    chk("lat_rsp_valid", rsp_valid, 1);
    chk("lat_idle_psel", PSEL, 0);
    wait_rsp(nrsp + 1);
    wait_cfg[3] = 3;
    dat_cfg[3] = 32'h12345678;
    exp_q.push_back('{32'h12345678, 1'b0, 1'b0});
    issue(1'b0, 16'hC004, 32'h0, 4'hF);
    count_access(n);
    chk("wait3_access_len", n, 4);
    chk("wait3_rsp_valid", rsp_valid, 1);
    wait_rsp(nrsp + 1);
    wait_cfg[0] = 1;
    wait_cfg[2] = 0;
    dat_cfg[2] = 32'hBEEF0002;
    exp_q.push_back('{32'h0, 1'b0, 1'b0});
    exp_q.push_back('{32'hBEEF0002, 1'b0, 1'b0});
    issue(1'b1, 16'h0010, 32'h0000F00D, 4'hC);
    c1 = cyc;
    issue(1'b0, 16'h8008, 32'h0, 4'hF);
    chk("b2b_gap", cyc - c1, 3);
    chk("b2b_psel", PSEL, 4'b0100);
    chk("b2b_penable_low", PENABLE, 0);
    chk("b2b_first_rsp", rsp_valid, 1);
    @(posedge clk);
    #1;
    chk("b2b_penable_high", PENABLE, 1);
    wait_rsp(nrsp + 1);
    wait_cfg[2] = 1000;
    exp_q.push_back('{32'h0, 1'b1, 1'b1});
    issue(1'b0, 16'h8000, 32'h0, 4'h0);
    count_access(n);
    chk("tmo_access_len", n, 16);
    chk("tmo_psel", PSEL, 0);
    chk("tmo_rsp_valid", rsp_valid, 1);
    chk("tmo_req_ready", req_ready, 1);
    wait_rsp(nrsp + 1);
    wait_cfg[2] = 15;
    dat_cfg[2] = 32'h0000600D;
    exp_q.push_back('{32'h0000600D, 1'b0, 1'b0});
    issue(1'b0, 16'h8000, 32'h0, 4'h0);
    count_access(n);
    chk("edge_access_len", n, 16);
    wait_rsp(nrsp + 1);
    wait_cfg[1] = 1000;
    issue(1'b1, 16'h4000, 32'h00001234, 4'hF);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_penable", PENABLE, 1);
    saved = nrsp;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_psel", PSEL, 0);
    chk("mid_rst_penable", PENABLE, 0);
    chk("mid_rst_pwrite", PWRITE, 0);
    chk("mid_rst_paddr", PADDR, 0);
    chk("mid_rst_pwdata", PWDATA, 0);
    chk("mid_rst_pstrb", PSTRB, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_req_ready", req_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_cfg[1] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_no_rsp", nrsp, saved);
    exp_q.push_back('{32'h0, 1'b0, 1'b0});
    issue(1'b1, 16'h4004, 32'h00005678, 4'hF);
    setup_chk(1'b1, 16'h4004, 32'h00005678, 4'hF);
    wait_rsp(nrsp + 1);
    repeat (2) @(posedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
